inst_injector: RTL and testbench



---
 rtl/inst_inj_pkg.sv | 13 +
 rtl/inst_fifo.sv | 67 ++++++
 rtl/inst_injector.sv | 159 +++++++++++++++
 tb/tb_inst_injector.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_inj_pkg.sv
// Shared types and constants for the external-instruction injector.
package inst_inj_pkg;

    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] NOP_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } inj_state_t;

endpackage

// File: rtl/inst_fifo.sv
// Synchronous instruction FIFO. The head word is read straight out of the
// storage registers, so it is valid whenever the FIFO is not empty.
// Flush empties the FIFO and drops any push in the same cycle.
module inst_fifo
    import inst_inj_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = INST_W
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [W-1:0]             head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] count_q;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == {CW{1'b0}});
    assign push_ok_s = push_i && !full_o && !flush_i;
    assign pop_ok_s  = pop_i && !empty_o && !flush_i;
    assign head_o    = mem_q[rd_q];
    assign count_o   = count_q;

    // Storage write; stale contents are harmless because the pointers gate reads.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_q[wr_q] <= data_i;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wr_q    <= {AW{1'b0}};
            rd_q    <= {AW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_q <= wr_q + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_q <= rd_q + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_q <= count_q - {{(CW-1){1'b0}}, 1'b1};
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/inst_injector.sv
// Host-side driver for the CPU external-instruction override port. Buffers
// host words and issues one registered word per clock while running,
// padding with NOP bubbles when starved and releasing the CPU when idle.
module inst_injector
    import inst_inj_pkg::*;
#(
    parameter int                 DEPTH    = 8,
    parameter logic [INST_W-1:0]  NOP_WORD = NOP_DEFAULT,
    parameter int                 CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    input  logic [INST_W-1:0]        s_data,
    output logic                     s_ready,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     flush,
    output logic [INST_W-1:0]        extInst,
    output logic                     extInst_en,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         issued_cnt,
    output logic [CNT_W-1:0]         bubble_cnt
);

    inj_state_t          state_q, state_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic                en_q, en_d;
    logic [CNT_W-1:0]    iss_q, iss_d;
    logic [CNT_W-1:0]    bub_q, bub_d;
    logic [CNT_W-1:0]    iss_base_s;
    logic [CNT_W-1:0]    bub_base_s;
    logic                do_issue_s;
    logic                clear_s;
    logic                pop_s;
    logic                full_s;
    logic                empty_s;
    logic [INST_W-1:0]   head_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    inst_fifo #(
        .DEPTH (DEPTH),
        .W     (INST_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (s_valid),
        .data_i  (s_data),
        .pop_i   (pop_s),
        .flush_i (flush),
        .head_o  (head_s),
        .count_o (fifo_count),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    assign s_ready    = !full_s;
    assign extInst    = inst_q;
    assign extInst_en = en_q;
    assign busy       = (state_q != IDLE);
    assign issued_cnt = iss_q;
    assign bubble_cnt = bub_q;

    // Next-state, issue decision and counter update; flush overrides everything.
    always_comb begin
        state_d    = state_q;
        inst_d     = inst_q;
        en_d       = en_q;
        iss_d      = iss_q;
        bub_d      = bub_q;
        do_issue_s = 1'b0;
        clear_s    = 1'b0;
        pop_s      = 1'b0;

        if (flush) begin
            state_d = IDLE;
            inst_d  = {INST_W{1'b0}};
            en_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    inst_d = {INST_W{1'b0}};
                    en_d   = 1'b0;
                    if (start && !stop) begin
                        state_d    = RUN;
                        clear_s    = 1'b1;
                        do_issue_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    do_issue_s = 1'b1;
                    state_d    = stop ? DRAIN : RUN;
                end
                DRAIN: begin
                    if (start && !stop) begin
                        state_d    = RUN;
                        do_issue_s = 1'b1;
                    end else if (!empty_s) begin
                        do_issue_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                        inst_d  = {INST_W{1'b0}};
                        en_d    = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    inst_d  = {INST_W{1'b0}};
                    en_d    = 1'b0;
                end
            endcase
        end

        // A start from IDLE restarts both counters before this edge's issue is counted.
        iss_base_s = clear_s ? {CNT_W{1'b0}} : iss_q;
        bub_base_s = clear_s ? {CNT_W{1'b0}} : bub_q;

        if (do_issue_s) begin
            en_d = 1'b1;
            if (!empty_s) begin
                pop_s  = 1'b1;
                inst_d = head_s;
                iss_d  = sat_inc(iss_base_s);
                bub_d  = bub_base_s;
            end else begin
                inst_d = NOP_WORD;
                iss_d  = iss_base_s;
                bub_d  = sat_inc(bub_base_s);
            end
        end else begin
            iss_d = iss_q;
            bub_d = bub_q;
        end
    end

    // State, output and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            inst_q  <= {INST_W{1'b0}};
            en_q    <= 1'b0;
            iss_q   <= {CNT_W{1'b0}};
            bub_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            en_q    <= en_d;
            iss_q   <= iss_d;
            bub_q   <= bub_d;
        end
    end

endmodule

// File: tb/tb_inst_injector.sv
// Self-checking bench for inst_injector: a cycle table for the scripted
// scenarios plus a scoreboard of pushed words for the ordering sequences.
module tb_inst_injector;
    import inst_inj_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = 32'h0;
    logic        s_ready;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] extInst;
    logic        extInst_en;
    logic        busy;
    logic [3:0]  fifo_count;
    logic [3:0]  issued_cnt;
    logic [3:0]  bubble_cnt;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        rst;
        logic        v;
        logic [31:0] d;
        logic        st;
        logic        sp;
        logic        fl;
        logic        en;
        logic [31:0] inst;
        int          cnt;
        logic        busy;
        int          iss;
        int          bub;
    } vec_t;

    vec_t vecs[$];

    inst_injector #(
        .DEPTH    (8),
        .NOP_WORD (32'h0000_0000),
        .CNT_W    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .start      (start),
        .stop       (stop),
        .flush      (flush),
        .extInst    (extInst),
        .extInst_en (extInst_en),
        .busy       (busy),
        .fifo_count (fifo_count),
        .issued_cnt (issued_cnt),
        .bubble_cnt (bubble_cnt)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic v, input logic [31:0] d,
                                input logic st, input logic sp, input logic fl,
                                input logic en, input logic [31:0] inst, input int cnt,
                                input logic bz, input int iss, input int bub);
        vec_t t;
        t.rst = r; t.v = v; t.d = d; t.st = st; t.sp = sp; t.fl = fl;
        t.en = en; t.inst = inst; t.cnt = cnt; t.busy = bz; t.iss = iss; t.bub = bub;
        return t;
    endfunction

    // Compare the current output against the scoreboard if a word is being issued.
    task automatic chk_issue();
        if (extInst_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", extInst, 32'hFFFF_FFFF);
            end else begin
                chk("issue_word", extInst, exp_q.pop_front());
            end
        end
    endtask

    // Pulse stop, then follow the drain until the CPU is released.
    task automatic collect_with_stop();
        int done;
        done = 0;
        for (int c = 0; c < 40; c++) begin
            stop = (c == 0);
            tick();
            stop = 1'b0;
            chk_issue();
            if (!busy && !extInst_en) begin
                done = 1;
                break;
            end
        end
        chk("drain_done", 32'(done), 32'd1);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // rst v  data          st sp fl | en inst          cnt busy iss bub
        vecs.push_back(mk(0,0,32'h0,          0,0,0, 0,32'h0,          0,0,0,0));
        vecs.push_back(mk(1,1,32'h2008_0005,  0,0,0, 0,32'h0,          1,0,0,0));
        vecs.push_back(mk(1,1,32'h2009_0003,  0,0,0, 0,32'h0,          2,0,0,0));
        vecs.push_back(mk(1,1,32'h0109_5020,  0,0,0, 0,32'h0,          3,0,0,0));
        vecs.push_back(mk(1,0,32'h0,          1,0,0, 1,32'h2008_0005,  2,1,1,0));
        vecs.push_back(mk(1,0,32'h0,          0,0,0, 1,32'h2009_0003,  1,1,2,0));
        vecs.push_back(mk(1,0,32'h0,          0,0,0, 1,32'h0109_5020,  0,1,3,0));
        vecs.push_back(mk(1,0,32'h0,          0,0,0, 1,32'h0,          0,1,3,1));
        vecs.push_back(mk(1,0,32'h0,          0,0,0, 1,32'h0,          0,1,3,2));
        vecs.push_back(mk(1,0,32'h0,          0,1,0, 1,32'h0,          0,1,3,3));
        vecs.push_back(mk(1,0,32'h0,          0,0,0, 0,32'h0,          0,0,3,3));
        // starvation
        vecs.push_back(mk(1,0,32'h0,          1,0,0, 1,32'h0,          0,1,0,1));
        vecs.push_back(mk(1,0,32'h0,          0,0,0, 1,32'h0,          0,1,0,2));
        vecs.push_back(mk(1,0,32'h0,          0,0,0, 1,32'h0,          0,1,0,3));
        vecs.push_back(mk(1,1,32'hAC0A_0000,  0,0,0, 1,32'h0,          1,1,0,4));
        vecs.push_back(mk(1,0,32'h0,          0,0,0, 1,32'hAC0A_0000,  0,1,1,4));
        vecs.push_back(mk(1,0,32'h0,          0,1,0, 1,32'h0,          0,1,1,5));
        vecs.push_back(mk(1,0,32'h0,          0,0,0, 0,32'h0,          0,0,1,5));
        // start and stop together from IDLE
        vecs.push_back(mk(1,0,32'h0,          1,1,0, 0,32'h0,          0,0,1,5));
        // flush mid-run
        vecs.push_back(mk(1,1,32'h1000_0001,  0,0,0, 0,32'h0,          1,0,1,5));
        vecs.push_back(mk(1,1,32'h1000_0002,  0,0,0, 0,32'h0,          2,0,1,5));
        vecs.push_back(mk(1,1,32'h1000_0003,  0,0,0, 0,32'h0,          3,0,1,5));
        vecs.push_back(mk(1,1,32'h1000_0004,  0,0,0, 0,32'h0,          4,0,1,5));
        vecs.push_back(mk(1,1,32'h1000_0005,  0,0,0, 0,32'h0,          5,0,1,5));
        vecs.push_back(mk(1,0,32'h0,          1,0,0, 1,32'h1000_0001,  4,1,1,0));
        vecs.push_back(mk(1,1,32'h1000_0099,  0,0,1, 0,32'h0,          0,0,1,0));
        // reset mid-run
        vecs.push_back(mk(1,1,32'h2000_0001,  0,0,0, 0,32'h0,          1,0,1,0));
        vecs.push_back(mk(1,0,32'h0,          1,0,0, 1,32'h2000_0001,  0,1,1,0));
        vecs.push_back(mk(1,1,32'h2000_0002,  0,0,0, 1,32'h0,          1,1,1,1));
        vecs.push_back(mk(0,1,32'h2000_0003,  0,0,0, 0,32'h0,          0,0,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; s_valid = vecs[i].v; s_data = vecs[i].d;
            start = vecs[i].st; stop = vecs[i].sp; flush = vecs[i].fl;
            tick();
            chk($sformatf("v%0d_en", i),    32'(extInst_en), 32'(vecs[i].en));
            chk($sformatf("v%0d_inst", i),  extInst,         vecs[i].inst);
            chk($sformatf("v%0d_count", i), 32'(fifo_count), 32'(vecs[i].cnt));
            chk($sformatf("v%0d_busy", i),  32'(busy),       32'(vecs[i].busy));
            chk($sformatf("v%0d_ready", i), 32'(s_ready),    32'd1);
            chk($sformatf("v%0d_iss", i),   32'(issued_cnt), 32'(vecs[i].iss));
            chk($sformatf("v%0d_bub", i),   32'(bubble_cnt), 32'(vecs[i].bub));
        end
        rst = 1'b1; s_valid = 1'b0; start = 1'b0; stop = 1'b0; flush = 1'b0;
        tick();

        // Full FIFO and back-pressure, then in-order drain.
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1;
            s_data  = 32'h3000_0000 + 32'(i);
            exp_q.push_back(s_data);
            tick();
        end
        chk("full_ready", 32'(s_ready), 32'd0);
        chk("full_count", 32'(fifo_count), 32'd8);
        s_data = 32'hDEAD_BEEF;
        tick();
        chk("ninth_count", 32'(fifo_count), 32'd8);
        s_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ready_after_pop", 32'(s_ready), 32'd1);
        chk_issue();
        collect_with_stop();
        chk("full_issued", 32'(issued_cnt), 32'd8);
        chk("full_bubbles", 32'(bubble_cnt), 32'd0);

        // Saturation of issued_cnt at 15 after 17 issues.
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1;
            s_data  = 32'h4000_0000 + 32'(i);
            exp_q.push_back(s_data);
            tick();
        end
        s_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_issue();
        for (int k = 0; k < 9; k++) begin
            s_valid = 1'b1;
            s_data  = 32'h5000_0000 + 32'(k);
            if (s_ready) exp_q.push_back(s_data);
            tick();
            chk_issue();
        end
        s_valid = 1'b0;
        chk("pre_stop_issued", 32'(issued_cnt), 32'd10);
        collect_with_stop();
        chk("sat_issued", 32'(issued_cnt), 32'd15);
        chk("sat_bubbles", 32'(bubble_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
